// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle CPU, sequencing fetch/decode/execute/mem/writeback.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TMO_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic [3:0] state_o,
  output logic [5:0] ALUOp_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       PCWrite_o,
  output logic       RegWrite_o,
  output logic [1:0] PCSrc_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       err_o
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP
  } state_t;
  state_t state, nxt;
  logic [TMO_W-1:0] cnt;
  logic mem_st, tmo, ok, legal;
  assign mem_st = state inside {FETCH, MEM_RD, MEM_WR};
  assign tmo = mem_st && !mem_ready_i && cnt == TMO_W'(TIMEOUT - 1);
  // reset and timeout both suppress every strobe in the current cycle
  assign ok = !rst_i && !tmo;
  assign legal = instr_op_i inside {6'b000000, 6'b100011, 6'b101011, 6'b001000,
                                    6'b001010, 6'b000100, 6'b000101, 6'b000010};
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:     nxt = err_o ? IDLE : FETCH;
      FETCH:    nxt = mem_ready_i ? DECODE : FETCH;
      DECODE:   nxt = instr_op_i == 6'b000000 ? R_EXEC :
                      instr_op_i inside {6'b100011, 6'b101011} ? MEM_ADDR :
                      instr_op_i inside {6'b001000, 6'b001010} ? I_EXEC :
                      instr_op_i inside {6'b000100, 6'b000101} ? BRANCH :
                      instr_op_i == 6'b000010 ? JUMP : FETCH;
      MEM_ADDR: nxt = instr_op_i == 6'b101011 ? MEM_WR : MEM_RD;
      MEM_RD:   nxt = mem_ready_i ? MEM_WB : MEM_RD;
      MEM_WR:   nxt = mem_ready_i ? FETCH : MEM_WR;
      R_EXEC:   nxt = R_WB;
      I_EXEC:   nxt = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: nxt = FETCH;
      default:  nxt = IDLE;
    endcase
    if (tmo) nxt = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      err_o <= 1'b0;
    end else begin
      state <= nxt;
      err_o <= err_o | tmo;
      cnt <= nxt != state ? '0 :
             (mem_st && !mem_ready_i && cnt != TMO_W'(TIMEOUT)) ? cnt + TMO_W'(1) : cnt;
    end
  end
  assign state_o = state;
  assign ALUOp_o = state == R_EXEC ? 6'b000010 :
                   state == I_EXEC ? instr_op_i :
                   state == BRANCH ? 6'b000001 : 6'b000000;
  assign ALUSrcA_o = state inside {MEM_ADDR, R_EXEC, I_EXEC, BRANCH};
  assign ALUSrcB_o = state == FETCH ? 2'b01 :
                     state == DECODE ? 2'b11 :
                     state inside {MEM_ADDR, I_EXEC} ? 2'b10 : 2'b00;
  assign IorD_o = state inside {MEM_RD, MEM_WR};
  assign MemRead_o = ok && state inside {FETCH, MEM_RD};
  assign MemWrite_o = ok && state == MEM_WR;
  assign IRWrite_o = ok && state == FETCH && mem_ready_i;
  assign PCWrite_o = ok && ((state == FETCH && mem_ready_i) || state == JUMP ||
                            (state == BRANCH && (instr_op_i == 6'b000100 ? zero_i : !zero_i)));
  assign RegWrite_o = ok && state inside {MEM_WB, R_WB, I_WB};
  assign PCSrc_o = state == BRANCH ? 2'b01 : state == JUMP ? 2'b10 : 2'b00;
  assign RegDst_o = state == R_WB;
  assign MemtoReg_o = state == MEM_WB;
  assign instr_done_o = ok && (state inside {MEM_WB, R_WB, I_WB, BRANCH, JUMP} ||
                               (state == MEM_WR && mem_ready_i));
  assign illegal_o = ok && state == DECODE && !legal;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed walk through every instruction class, timeout and reset cases.
module tb_multicycle_ctrl;
  logic clk = 0, rst, ready, zero;
  logic [5:0] op;
  logic [3:0] state;
  logic [5:0] alu;
  logic sa, iord, mr, mw, ir, pcw, rw, rd, m2r, dn, il, er;
  logic [1:0] sb, pcs;
  int tests = 0, fails = 0;
  logic [25:0] exp_q[$];
  string tag_q[$];
  localparam logic [11:0] SA = 12'h800, IORD = 12'h400, MR = 12'h200, MW = 12'h100,
                          IR = 12'h080, PCW = 12'h040, RW = 12'h020, RD = 12'h010,
                          M2R = 12'h008, DN = 12'h004, IL = 12'h002, ER = 12'h001;
  always #5 clk = ~clk;
  multicycle_ctrl #(.TIMEOUT(4), .TMO_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .mem_ready_i(ready), .zero_i(zero),
    .state_o(state), .ALUOp_o(alu), .ALUSrcA_o(sa), .ALUSrcB_o(sb), .IorD_o(iord),
    .MemRead_o(mr), .MemWrite_o(mw), .IRWrite_o(ir), .PCWrite_o(pcw), .RegWrite_o(rw),
    .PCSrc_o(pcs), .RegDst_o(rd), .MemtoReg_o(m2r), .instr_done_o(dn), .illegal_o(il),
    .err_o(er)
  );
  task automatic cyc(input string tag, input logic [3:0] st, input logic [5:0] a,
                     input logic [1:0] b, input logic [1:0] p, input logic [11:0] fl);
    logic [25:0] obs, want;
    string t;
    exp_q.push_back({st, a, b, p, fl});
    tag_q.push_back(tag);
    #1;
    obs = {state, alu, sb, pcs, sa, iord, mr, mw, ir, pcw, rw, rd, m2r, dn, il, er};
    want = exp_q.pop_front();
    t = tag_q.pop_front();
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", t, obs, want);
    end
    @(negedge clk);
  endtask
  initial begin
    rst = 1; ready = 0; zero = 0; op = 6'b000000;
    repeat (2) @(negedge clk);
    cyc("reset", 0, 0, 0, 0, 0);
    rst = 0; ready = 1;
    cyc("idle", 0, 0, 0, 0, 0);
    cyc("r_fetch", 1, 0, 2'b01, 0, MR | IR | PCW);
    cyc("r_decode", 2, 0, 2'b11, 0, 0);
    cyc("r_exec", 7, 6'b000010, 2'b00, 0, SA);
    cyc("r_wb", 8, 0, 0, 0, RW | RD | DN);
    op = 6'b100011;
    cyc("lw_fetch", 1, 0, 2'b01, 0, MR | IR | PCW);
    cyc("lw_decode", 2, 0, 2'b11, 0, 0);
    cyc("lw_addr", 3, 0, 2'b10, 0, SA);
    ready = 0;
    cyc("lw_wait1", 4, 0, 0, 0, IORD | MR);
    cyc("lw_wait2", 4, 0, 0, 0, IORD | MR);
    cyc("lw_wait3", 4, 0, 0, 0, IORD | MR);
    ready = 1;
    cyc("lw_rd", 4, 0, 0, 0, IORD | MR);
    cyc("lw_wb", 5, 0, 0, 0, RW | M2R | DN);
    op = 6'b000100; zero = 1;
    cyc("beq_fetch", 1, 0, 2'b01, 0, MR | IR | PCW);
    cyc("beq_decode", 2, 0, 2'b11, 0, 0);
    cyc("beq_taken", 11, 6'b000001, 0, 2'b01, SA | PCW | DN);
    op = 6'b000101;
    cyc("bne_fetch", 1, 0, 2'b01, 0, MR | IR | PCW);
    cyc("bne_decode", 2, 0, 2'b11, 0, 0);
    cyc("bne_not_taken", 11, 6'b000001, 0, 2'b01, SA | DN);
    op = 6'b111111; zero = 0;
    cyc("ill_fetch", 1, 0, 2'b01, 0, MR | IR | PCW);
    cyc("ill_decode", 2, 0, 2'b11, 0, IL);
    op = 6'b001000;
    cyc("addi_fetch", 1, 0, 2'b01, 0, MR | IR | PCW);
    cyc("addi_decode", 2, 0, 2'b11, 0, 0);
    rst = 1;
    cyc("addi_exec_rst", 9, 6'b001000, 2'b10, 0, SA);
    rst = 0; ready = 0;
    cyc("after_rst_idle", 0, 0, 0, 0, 0);
    cyc("tmo_wait1", 1, 0, 2'b01, 0, MR);
    cyc("tmo_wait2", 1, 0, 2'b01, 0, MR);
    cyc("tmo_wait3", 1, 0, 2'b01, 0, MR);
    cyc("tmo_hit", 1, 0, 2'b01, 0, 0);
    cyc("err_idle1", 0, 0, 0, 0, ER);
    ready = 1;
    cyc("err_idle2", 0, 0, 0, 0, ER);
    rst = 1;
    cyc("err_rst", 0, 0, 0, 0, ER);
    rst = 0;
    cyc("err_cleared", 0, 0, 0, 0, 0);
    op = 6'b101011;
    cyc("sw_fetch", 1, 0, 2'b01, 0, MR | IR | PCW);
    cyc("sw_decode", 2, 0, 2'b11, 0, 0);
    cyc("sw_addr", 3, 0, 2'b10, 0, SA);
    cyc("sw_wr", 6, 0, 0, 0, IORD | MW | DN);
    op = 6'b000010;
    cyc("j_fetch", 1, 0, 2'b01, 0, MR | IR | PCW);
    cyc("j_decode", 2, 0, 2'b11, 0, 0);
    cyc("j_jump", 12, 0, 0, 2'b10, PCW | DN);
    cyc("j_next_fetch", 1, 0, 2'b01, 0, MR | IR | PCW);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
